// File: rtl/snake_motion_engine_if.sv
// Bundle between the snake motion engine, its input/renderer side and the
// score tracker. Clock and reset are not part of the bundle.
//
// Handshake: `tick` is a one-cycle request that is accepted only in a cycle
// where `busy` is low; a `tick` seen while `busy` is high is dropped, not
// queued. The result of an accepted move appears as a one-cycle
// `goodColl`/`badColl`/`apple_req` pulse in the first cycle `busy` is low
// again, and a new `tick` may be issued in that very cycle.
interface snake_motion_engine_if #(
    parameter int IDXW = 4,
    parameter int LENW = 5
);
    logic            tick;
    logic [3:0]      dir_i;
    logic [2:0]      apple_x;
    logic [2:0]      apple_y;
    logic            apple_valid;
    logic [IDXW-1:0] rd_idx;
    logic [2:0]      rd_x;
    logic [2:0]      rd_y;
    logic            rd_valid;
    logic [2:0]      head_x;
    logic [2:0]      head_y;
    logic [LENW-1:0] length;
    logic            busy;
    logic            goodColl;
    logic            badColl;
    logic            apple_req;
    logic [1:0]      state;

    modport master (
        output tick, dir_i, apple_x, apple_y, apple_valid, rd_idx,
        input  rd_x, rd_y, rd_valid, head_x, head_y, length, busy,
               goodColl, badColl, apple_req, state
    );

    modport slave (
        input  tick, dir_i, apple_x, apple_y, apple_valid, rd_idx,
        output rd_x, rd_y, rd_valid, head_x, head_y, length, busy,
               goodColl, badColl, apple_req, state
    );
endinterface

// File: rtl/snake_motion_engine.sv
// Snake body on an 8x8 grid: advances one cell per accepted tick, scans the
// body one segment per cycle for a self hit, then commits the move or
// restarts the snake, and pulses goodColl/badColl for the score tracker.
module snake_motion_engine #(
    parameter int MAX_LEN = 16,
    parameter int IDXW    = 4,
    parameter int LENW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    snake_motion_engine_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Direction codes chosen so that the opposite direction is code ^ 1.
    localparam logic [1:0] D_RIGHT = 2'd0;
    localparam logic [1:0] D_LEFT  = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_UP    = 2'd3;

    state_t          state_q, state_d;
    logic [2:0]      seg_x [MAX_LEN];
    logic [2:0]      seg_y [MAX_LEN];
    logic [LENW-1:0] len_q;
    logic [IDXW-1:0] idx_q;
    logic [1:0]      last_dir_q, pend_dir_q, move_dir_q;
    logic [2:0]      nxt_x_q, nxt_y_q;
    logic            wall_q, grow_q, hit_q;
    logic            good_q, bad_q, areq_q;

    logic [1:0]      cand_dir;
    logic            dir_ok;
    logic [2:0]      step_x, step_y;
    logic            off_grid;
    logic            eats;
    logic            last_idx;

    assign last_idx = (LENW'(idx_q) == len_q - LENW'(1));

    // Pick the highest-priority requested direction and reject reversals.
    always_comb begin
        cand_dir = D_RIGHT;
        if (bus.dir_i[3])      cand_dir = D_UP;
        else if (bus.dir_i[2]) cand_dir = D_DOWN;
        else if (bus.dir_i[1]) cand_dir = D_LEFT;
        dir_ok = (bus.dir_i != 4'd0) && (cand_dir != (last_dir_q ^ 2'b01));
    end

    // Candidate next head from the pending direction; no wrap-around.
    always_comb begin
        step_x   = seg_x[0];
        step_y   = seg_y[0];
        off_grid = 1'b0;
        case (pend_dir_q)
            D_RIGHT: begin off_grid = (seg_x[0] == 3'd7); step_x = seg_x[0] + 3'd1; end
            D_LEFT:  begin off_grid = (seg_x[0] == 3'd0); step_x = seg_x[0] - 3'd1; end
            D_DOWN:  begin off_grid = (seg_y[0] == 3'd7); step_y = seg_y[0] + 3'd1; end
            default: begin off_grid = (seg_y[0] == 3'd0); step_y = seg_y[0] - 3'd1; end
        endcase
        eats = bus.apple_valid && (step_x == bus.apple_x) &&
               (step_y == bus.apple_y) && !off_grid;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: IDLE -> SCAN on tick, SCAN until the tail, COMMIT for one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.tick) state_d = S_SCAN;
            S_SCAN:   if (last_idx) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Body, direction registers, scan bookkeeping and result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= 3'd0;
                seg_y[i] <= 3'd0;
            end
            seg_x[0]   <= 3'd3;
            seg_y[0]   <= 3'd3;
            seg_x[1]   <= 3'd2;
            seg_y[1]   <= 3'd3;
            len_q      <= LENW'(2);
            idx_q      <= '0;
            last_dir_q <= D_RIGHT;
            pend_dir_q <= D_RIGHT;
            move_dir_q <= D_RIGHT;
            nxt_x_q    <= 3'd0;
            nxt_y_q    <= 3'd0;
            wall_q     <= 1'b0;
            grow_q     <= 1'b0;
            hit_q      <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            areq_q     <= 1'b0;
        end else begin
            good_q <= 1'b0;
            bad_q  <= 1'b0;
            areq_q <= 1'b0;
            if (dir_ok) pend_dir_q <= cand_dir;
            case (state_q)
                S_IDLE: begin
                    if (bus.tick) begin
                        move_dir_q <= pend_dir_q;
                        nxt_x_q    <= step_x;
                        nxt_y_q    <= step_y;
                        wall_q     <= off_grid;
                        grow_q     <= eats;
                        idx_q      <= '0;
                        hit_q      <= 1'b0;
                    end
                end
                S_SCAN: begin
                    // The tail moves away this step unless the snake grows.
                    if (seg_x[idx_q] == nxt_x_q && seg_y[idx_q] == nxt_y_q &&
                        !(last_idx && !grow_q))
                        hit_q <= 1'b1;
                    if (!last_idx) idx_q <= idx_q + 1'b1;
                end
                S_COMMIT: begin
                    if (wall_q || hit_q) begin
                        seg_x[0]   <= 3'd3;
                        seg_y[0]   <= 3'd3;
                        seg_x[1]   <= 3'd2;
                        seg_y[1]   <= 3'd3;
                        len_q      <= LENW'(2);
                        last_dir_q <= D_RIGHT;
                        pend_dir_q <= D_RIGHT;
                        bad_q      <= 1'b1;
                    end else begin
                        for (int i = MAX_LEN - 1; i >= 1; i--) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        seg_x[0] <= nxt_x_q;
                        seg_y[0] <= nxt_y_q;
                        if (grow_q) begin
                            if (len_q != LENW'(MAX_LEN)) len_q <= len_q + 1'b1;
                            good_q <= 1'b1;
                            areq_q <= 1'b1;
                        end
                        last_dir_q <= move_dir_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_x      = seg_x[bus.rd_idx];
    assign bus.rd_y      = seg_y[bus.rd_idx];
    assign bus.rd_valid  = (LENW'(bus.rd_idx) < len_q);
    assign bus.head_x    = seg_x[0];
    assign bus.head_y    = seg_y[0];
    assign bus.length    = len_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.goodColl  = good_q;
    assign bus.badColl   = bad_q;
    assign bus.apple_req = areq_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_snake_motion_engine.sv
// Bench for snake_motion_engine: a behavioural snake model predicts each move
// result, which is queued when the tick is driven and compared at the pulse.
module tb_snake_motion_engine;
    localparam int W = 14;  // {good, bad, apple_req, head_x, head_y, length}

    logic clk = 1'b0;
    logic rst = 1'b1;
    snake_motion_engine_if bus ();

    snake_motion_engine dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q [$];

    int         m_x [16];
    int         m_y [16];
    int         m_len;
    logic [3:0] m_last, m_pend;
    int         a_x, a_y;
    logic       a_v;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] opposite(input logic [3:0] d);
        case (d)
            4'b1000: return 4'b0100;
            4'b0100: return 4'b1000;
            4'b0010: return 4'b0001;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic model_reset();
        m_len  = 2;
        m_x[0] = 3; m_y[0] = 3;
        m_x[1] = 2; m_y[1] = 3;
        m_last = 4'b0001;
        m_pend = 4'b0001;
    endtask

    task automatic model_next(output int nx, output int ny);
        nx = m_x[0];
        ny = m_y[0];
        case (m_pend)
            4'b1000: ny = ny - 1;
            4'b0100: ny = ny + 1;
            4'b0010: nx = nx - 1;
            default: nx = nx + 1;
        endcase
    endtask

    task automatic model_tick(output logic [W-1:0] e);
        int nx, ny;
        logic wall, grow, hit;
        model_next(nx, ny);
        wall = (nx < 0) || (nx > 7) || (ny < 0) || (ny > 7);
        grow = a_v && (nx == a_x) && (ny == a_y) && !wall;
        hit  = 1'b0;
        for (int i = 0; i < m_len; i++)
            if (!(i == m_len - 1 && !grow) && m_x[i] == nx && m_y[i] == ny) hit = 1'b1;
        if (wall || hit) begin
            model_reset();
            e = {1'b0, 1'b1, 1'b0, 3'd3, 3'd3, 5'd2};
        end else begin
            for (int i = 15; i >= 1; i--) begin
                m_x[i] = m_x[i-1];
                m_y[i] = m_y[i-1];
            end
            m_x[0] = nx;
            m_y[0] = ny;
            if (grow && m_len < 16) m_len++;
            m_last = m_pend;
            e = {grow, 1'b0, grow, 3'(nx), 3'(ny), 5'(m_len)};
        end
    endtask

    task automatic set_apple(input int x, input int y, input logic v);
        a_x = x; a_y = y; a_v = v;
        bus.apple_x     = 3'(x);
        bus.apple_y     = 3'(y);
        bus.apple_valid = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.tick = 1'b0;
        bus.dir_i = 4'd0;
        bus.rd_idx = '0;
        set_apple(0, 0, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        model_reset();
        exp_q.delete();
    endtask

    task automatic send_dir(input logic [3:0] d);
        logic [3:0] cand;
        bus.dir_i = d;
        step();
        bus.dir_i = 4'd0;
        if (d != 4'd0) begin
            cand = d[3] ? 4'b1000 : d[2] ? 4'b0100 : d[1] ? 4'b0010 : 4'b0001;
            if (cand != opposite(m_last)) m_pend = cand;
        end
    endtask

    // Issue one tick (optionally held into the busy window) and check the
    // busy window length and the result pulse. Returns in the pulse cycle.
    task automatic do_tick(input logic hold);
        logic [W-1:0] e, got;
        int n, exp_busy;
        exp_busy = m_len + 1;
        model_tick(e);
        exp_q.push_back(e);
        bus.tick = 1'b1;
        step();
        if (!hold) bus.tick = 1'b0;
        n_cmp++;
        if (bus.goodColl !== 1'b0 || bus.badColl !== 1'b0 || bus.apple_req !== 1'b0) begin
            n_err++;
            $display("FAIL pulse_after_tick: got good=%b bad=%b req=%b, want all 0",
                     bus.goodColl, bus.badColl, bus.apple_req);
        end
        n = 0;
        for (int k = 0; k < 40 && bus.busy === 1'b1; k++) begin
            n++;
            step();
            bus.tick = 1'b0;
        end
        bus.tick = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_timeout: busy=%b after 40 cycles, want 0", bus.busy);
        end
        n_cmp++;
        if (n != exp_busy) begin
            n_err++;
            $display("FAIL busy_cycles: got %0d, want %0d", n, exp_busy);
        end
        got = {bus.goodColl, bus.badColl, bus.apple_req, bus.head_x, bus.head_y, bus.length};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL move_result: got g/b/r=%b%b%b head=(%0d,%0d) len=%0d, want g/b/r=%b%b%b head=(%0d,%0d) len=%0d",
                     got[13], got[12], got[11], got[10:8], got[7:5], got[4:0],
                     e[13], e[12], e[11], e[10:8], e[7:5], e[4:0]);
        end
    endtask

    task automatic check_body();
        for (int i = 0; i < 16; i++) begin
            bus.rd_idx = 4'(i);
            step();
            n_cmp++;
            if (i < m_len) begin
                if (bus.rd_valid !== 1'b1 || bus.rd_x !== 3'(m_x[i]) || bus.rd_y !== 3'(m_y[i])) begin
                    n_err++;
                    $display("FAIL body[%0d]: got v=%b (%0d,%0d), want v=1 (%0d,%0d)",
                             i, bus.rd_valid, bus.rd_x, bus.rd_y, m_x[i], m_y[i]);
                end
            end else if (bus.rd_valid !== 1'b0) begin
                n_err++;
                $display("FAIL body_valid[%0d]: got %b, want 0", i, bus.rd_valid);
            end
        end
        bus.rd_idx = '0;
    endtask

    task automatic check_idle_snake(input string tag, input int hx, input int hy, input int len);
        n_cmp++;
        if (bus.head_x !== 3'(hx) || bus.head_y !== 3'(hy) || bus.length !== 5'(len) ||
            bus.busy !== 1'b0 || bus.goodColl !== 1'b0 || bus.badColl !== 1'b0 ||
            bus.apple_req !== 1'b0 || bus.state !== 2'd0) begin
            n_err++;
            $display("FAIL %s: got head=(%0d,%0d) len=%0d busy=%b g=%b b=%b r=%b st=%0d, want head=(%0d,%0d) len=%0d idle, no pulses",
                     tag, bus.head_x, bus.head_y, bus.length, bus.busy, bus.goodColl,
                     bus.badColl, bus.apple_req, bus.state, hx, hy, len);
        end
    endtask

    task automatic eat_step();
        int nx, ny;
        model_next(nx, ny);
        set_apple(nx, ny, 1'b1);
        do_tick(1'b0);
        set_apple(0, 0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        check_idle_snake("reset_state", 3, 3, 2);
        check_body();
    endtask

    task automatic test_move();
        do_reset();
        do_tick(1'b1);
        check_body();
    endtask

    task automatic test_grow();
        do_reset();
        set_apple(4, 3, 1'b1);
        do_tick(1'b0);
        set_apple(0, 0, 1'b0);
        check_body();
    endtask

    task automatic test_wall();
        do_reset();
        repeat (5) do_tick(1'b0);
        step();
        check_idle_snake("after_wall", 3, 3, 2);
        send_dir(4'b0010);
        do_tick(1'b0);
    endtask

    task automatic test_reverse();
        do_reset();
        send_dir(4'b0010);
        do_tick(1'b0);
        send_dir(4'b1010);
        do_tick(1'b0);
        check_body();
    endtask

    task automatic test_self_hit();
        do_reset();
        repeat (3) eat_step();
        send_dir(4'b1000); do_tick(1'b0);
        send_dir(4'b0010); do_tick(1'b0);
        send_dir(4'b0100); do_tick(1'b0);
        check_body();
    endtask

    task automatic test_tail_chase();
        do_reset();
        repeat (2) eat_step();
        repeat (2) begin
            send_dir(4'b1000); do_tick(1'b0);
            send_dir(4'b0010); do_tick(1'b0);
            send_dir(4'b0100); do_tick(1'b0);
            send_dir(4'b0001); do_tick(1'b0);
        end
        check_body();
    endtask

    task automatic test_max_len();
        do_reset();
        repeat (4) eat_step();
        send_dir(4'b1000);
        repeat (3) eat_step();
        send_dir(4'b0010);
        repeat (7) eat_step();
        send_dir(4'b0100);
        eat_step();
        check_body();
    endtask

    task automatic test_rst_mid_scan();
        do_reset();
        eat_step();
        step();
        send_dir(4'b1000);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check_idle_snake("rst_mid_scan", 3, 3, 2);
        step();
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            check_idle_snake("no_pulse_after_rst", 3, 3, 2);
        end
        do_tick(1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (3) do_tick(1'b0);
        step();
        check_idle_snake("after_back_to_back", 6, 3, 2);
    endtask

    task automatic test_random();
        int nx, ny;
        logic [3:0] d;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            d = 4'($urandom_range(0, 15));
            send_dir(d);
            model_next(nx, ny);
            if ($urandom_range(0, 1) == 1) set_apple(nx, ny, 1'b1);
            else set_apple($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            do_tick(1'b0);
        end
        set_apple(0, 0, 1'b0);
        step();
        check_body();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick = 1'b0;
        bus.dir_i = 4'd0;
        bus.rd_idx = '0;
        set_apple(0, 0, 1'b0);
        test_reset();
        test_move();
        test_grow();
        test_wall();
        test_reverse();
        test_self_hit();
        test_tail_chase();
        test_max_len();
        test_rst_mid_scan();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
